// File: rtl/mbadd_pkg.sv
// Shared definitions for the multi-byte add sequencer.
//   BYTE_W      : width of one adder slice
//   byte_t      : one operand/result byte
//   ST_IDLE/ST_RUN/ST_DONE : sequencer state encoding
package mbadd_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mbadd_sat.sv
// Signed saturation mux for the wide adder result.
// When the final overflow flag is set, the raw wrap-around sum is replaced by the largest
// positive value (A non-negative) or the most negative value (A negative). The zero flag is
// recomputed on the replaced value, which is never zero.
// Ports:
//   sum_in  : raw wide sum
//   v       : signed overflow of the most significant byte
//   a_msb   : sign bit of operand A
//   z_in    : zero flag of the raw sum
//   sum_out : saturated (or passed-through) sum
//   z_out   : zero flag of sum_out
module mbadd_sat
  import mbadd_pkg::*;
#(
  parameter int unsigned W = 4 * BYTE_W
) (
  input  logic [W-1:0] sum_in,
  input  logic         v,
  input  logic         a_msb,
  input  logic         z_in,
  output logic [W-1:0] sum_out,
  output logic         z_out
);

  logic [W-1:0] sat_val;

  always_comb begin
    // 0x7F..FF for a positive overflow, 0x80..00 for a negative one.
    sat_val = {a_msb, {(W-1){~a_msb}}};
    if (v) begin
      sum_out = sat_val;
      z_out   = 1'b0;
    end else begin
      sum_out = sum_in;
      z_out   = z_in;
    end
  end

endmodule

// File: rtl/mbyte_add_seq.sv
// Multi-byte add sequencer sitting in front of an external 8-bit ripple adder.
// Operands of NBYTES bytes are accepted over in_valid/in_ready, fed to the adder one byte per
// cycle LSB first with the carry chained between bytes, and the collected wide result plus
// C/V/Z flags are returned over out_valid/out_ready.
// Optional feature: define MBADD_SAT_EN to saturate the result on signed overflow.
// Ports:
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       : operand handshake; in_ready is high only while idle
//   in_a, in_b              : operands (NBYTES*8 bits)
//   in_cin                  : initial carry (1 for subtraction)
//   in_sub                  : invert B before adding
//   add_a, add_b, add_cin   : byte slice presented to the external adder (0 when not running)
//   add_sum, add_c, add_v, add_z : combinational adder results for the presented slice
//   out_valid/out_ready     : result handshake; result held while out_ready is low
//   out_sum, out_c, out_v, out_z : wide result and flags
module mbyte_add_seq
  import mbadd_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] in_a,
  input  logic [NBYTES*BYTE_W-1:0] in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic [BYTE_W-1:0]        add_a,
  output logic [BYTE_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [BYTE_W-1:0]        add_sum,
  input  logic                     add_c,
  input  logic                     add_v,
  input  logic                     add_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NBYTES*BYTE_W-1:0] out_sum,
  output logic                     out_c,
  output logic                     out_v,
  output logic                     out_z
);

  localparam int unsigned W     = NBYTES * BYTE_W;
  localparam int unsigned IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [1:0] state_q, state_d;

  byte_t [NBYTES-1:0] a_q;
  byte_t [NBYTES-1:0] b_q;    // already inverted for subtraction
  byte_t [NBYTES-1:0] sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               zacc_q; // running AND of the per-byte zero flags
  logic               c_q;
  logic               v_q;

  logic accept;
  logic run;
  logic last_byte;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign run       = (state_q == ST_RUN);
  assign accept    = in_valid && in_ready;
  assign last_byte = run && (idx_q == LAST_IDX);

  // Adder slice; idx_q never exceeds LAST_IDX while running.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (run) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q];
      add_cin = carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_byte) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_sub ? ~in_b : in_b;
        carry_q <= in_cin;
        zacc_q  <= 1'b1;
        idx_q   <= '0;
      end else if (run) begin
        sum_q[idx_q] <= add_sum;
        carry_q      <= add_c;
        zacc_q       <= zacc_q & add_z;
        if (last_byte) begin
          // Final C and V come from the most significant byte only.
          c_q   <= add_c;
          v_q   <= add_v;
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign out_c = c_q;
  assign out_v = v_q;

`ifdef MBADD_SAT_EN
  mbadd_sat #(
    .W (W)
  ) u_sat (
    .sum_in  (sum_q),
    .v       (v_q),
    .a_msb   (a_q[NBYTES-1][BYTE_W-1]),
    .z_in    (zacc_q),
    .sum_out (out_sum),
    .z_out   (out_z)
  );
`else
  assign out_sum = sum_q;
  assign out_z   = zacc_q;
`endif

endmodule

// File: tb/tb_mbyte_add_seq.sv
// Self-checking bench for mbyte_add_seq (NBYTES = 4). The bench models the external 8-bit
// adder and keeps a wide-arithmetic reference of the expected result and handshake timing.
module tb_mbyte_add_seq;

  localparam int NB = 4;
  localparam int W  = NB * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_c, add_v, add_z;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_c, out_v, out_z;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mbyte_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_c     (add_c),
    .add_v     (add_v),
    .add_z     (add_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z)
  );

  // External 8-bit ripple adder.
  always_comb begin
    {add_c, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    add_v = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
    add_z = (add_sum == 8'd0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Wide reference: {sum, c, v, z}.
  function automatic logic [W+2:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c, v, z;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    r  = t[W-1:0];
    c  = t[W];
    v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    z  = (r == '0);
`ifdef MBADD_SAT_EN
    if (v) begin
      r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      z = 1'b0;
    end
`endif
    return {r, c, v, z};
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] x, input int i);
    logic [W-1:0] t;
    t = x >> (8 * i);
    return t[7:0];
  endfunction

  // Carry into byte i: carry-out of the wide add restricted to the lower i bytes.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int i);
    logic [W:0] one, m, s;
    one = 1;
    m = (one << (8 * i)) - one;
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
    return s[8 * i];
  endfunction

  // Reference timing: m_wait = edges left until the result, m_have = result pending.
  int           m_wait = 0;
  bit           m_have = 1'b0;
  int           m_acc_cnt = 0;
  logic [W-1:0] m_a = '0, m_bb = '0;
  logic         m_cin = 1'b0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_c = 1'b0, exp_v = 1'b0, exp_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0;
      m_have <= 1'b0;
    end else if (m_have) begin
      if (out_ready) m_have <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_have <= 1'b1;
    end else if (in_valid) begin
      m_a       <= in_a;
      m_bb      <= in_sub ? ~in_b : in_b;
      m_cin     <= in_cin;
      {exp_sum, exp_c, exp_v, exp_z} <= ref_calc(in_a, in_b, in_cin, in_sub);
      m_wait    <= NB;
      m_acc_cnt <= m_acc_cnt + 1;
    end
  end

  // Per-cycle compare against the reference.
  int cidx;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(m_wait == 0 && !m_have));
      chk("out_valid", 64'(out_valid), 64'(m_have));
      if (m_have) begin
        chk("out_sum", 64'(out_sum), 64'(exp_sum));
        chk("out_c", 64'(out_c), 64'(exp_c));
        chk("out_v", 64'(out_v), 64'(exp_v));
        chk("out_z", 64'(out_z), 64'(exp_z));
      end
      if (m_wait > 0) begin
        cidx = NB - m_wait;
        chk("add_a", 64'(add_a), 64'(byte_of(m_a, cidx)));
        chk("add_b", 64'(add_b), 64'(byte_of(m_bb, cidx)));
        chk("add_cin", 64'(add_cin), 64'(carry_into(m_a, m_bb, m_cin, cidx)));
      end else begin
        chk("add_idle", 64'({add_a, add_b, add_cin}), 64'd0);
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub);
    int start;
    int n;
    start = m_acc_cnt;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_acc_cnt == start && n < 50);
    chk("accept", 64'(m_acc_cnt - start), 64'd1);
    #1 in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen; lat counts edges since the accept edge.
  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic handshake(input int dly);
    repeat (dly) @(negedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] s, input logic c, input logic v,
                     input logic z);
    chk({nm, "_sum"}, 64'(out_sum), 64'(s));
    chk({nm, "_c"}, 64'(out_c), 64'(c));
    chk({nm, "_v"}, 64'(out_v), 64'(v));
    chk({nm, "_z"}, 64'(out_z), 64'(z));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int start;
    int n;
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_flags", 64'({out_c, out_v, out_z}), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    #1 rst_n = 1'b1;

    // 1: byte carry propagation and latency
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result(lat);
    chk("t1_latency", 64'(lat), 64'd4);
    lit("t1", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    handshake(0);

    // 2: signed overflow
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result(lat);
`ifdef MBADD_SAT_EN
    lit("t2", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
    lit("t2", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
    handshake(1);

    // 3: subtraction to zero
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
    wait_result(lat);
    lit("t3", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    handshake(0);

    // 4: full carry-out
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result(lat);
    lit("t4", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    handshake(2);

    // 5: back-pressure with a second request pending
    issue(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
    in_a = 32'h0000_000A;
    in_b = 32'h0000_0005;
    in_cin = 1'b0;
    in_sub = 1'b0;
    in_valid = 1'b1;
    start = m_acc_cnt;
    wait_result(lat);
    chk("t5_latency", 64'(lat), 64'd4);
    held = out_sum;
    chk("t5_sum", 64'(held), 64'h1234);
    repeat (5) begin
      @(negedge clk);
      chk("t5_stable", 64'(out_sum), 64'(held));
      chk("t5_no_accept", 64'(m_acc_cnt), 64'(start));
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    #1 out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_acc_cnt == start && n < 10);
    chk("t5_accept_gap", 64'(n), 64'd1);
    #1 in_valid = 1'b0;
    wait_result(lat);
    lit("t5b", 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    handshake(0);

    // 6: reset in the middle of an operation
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_sum", 64'(out_sum), 64'd0);
    chk("t6_flags", 64'({out_c, out_v, out_z}), 64'd0);
    chk("t6_add", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("t6_in_ready", 64'(in_ready), 64'd1);
    issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    wait_result(lat);
    chk("t6_latency", 64'(lat), 64'd4);
    lit("t6", 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    handshake(0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ~ra;
        2: rb = 32'(($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
        default: rb = $urandom;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_result(lat);
      chk("rnd_latency", 64'(lat), 64'd4);
      handshake($urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
